// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, registered instruction and IDLE/RUN/HALT control.
// Define FETCH_COUNT_EN to include a saturating count of instruction loads on FetchCount.
module inst_fetch #(
  parameter int                   A_WIDTH   = 11,
  parameter int                   I_WIDTH   = 9,
  parameter logic [I_WIDTH-1:0]   HALT_WORD = '1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [A_WIDTH-1:0] StartAddr,
  input  logic               Stall,
  input  logic               BranchEn,
  input  logic               BranchRel,
  input  logic [A_WIDTH-1:0] Target,
  input  logic [I_WIDTH-1:0] InstIn,
  output logic [A_WIDTH-1:0] InstAddress,
  output logic [I_WIDTH-1:0] InstReg,
  output logic [A_WIDTH-1:0] InstRegAddr,
  output logic               InstValid,
  output logic               Done,
  output logic [15:0]        FetchCount
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic [I_WIDTH-1:0] inst_q, inst_d;
  logic [A_WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic               valid_q, valid_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      inst_addr_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    valid_d     = valid_q;
    if (Start) begin
      state_d = RUN;
      pc_d    = StartAddr;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (BranchEn) begin
            // Relative target is taken from the instruction that issued the branch.
            pc_d    = BranchRel ? (inst_addr_q + Target) : Target;
            valid_d = 1'b0;
          end else if (!Stall) begin
            inst_d      = InstIn;
            inst_addr_d = pc_q;
            valid_d     = 1'b1;
            if (InstIn == HALT_WORD) begin
              state_d = HALT;
            end else begin
              pc_d = pc_q + A_WIDTH'(1);
            end
          end
        end
        HALT:    valid_d = 1'b0;
        default: valid_d = 1'b0;
      endcase
    end
  end

  assign InstAddress = pc_q;
  assign InstReg     = inst_q;
  assign InstRegAddr = inst_addr_q;
  assign InstValid   = valid_q;
  assign Done        = (state_q == HALT);

`ifdef FETCH_COUNT_EN
  logic        load;
  logic [15:0] fcount_q;

  assign load = (state_q == RUN) && !Start && !BranchEn && !Stall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fcount_q <= '0;
    end else if (Start) begin
      fcount_q <= '0;
    end else if (load && (fcount_q != 16'hFFFF)) begin
      fcount_q <= fcount_q + 16'd1;
    end
  end

  assign FetchCount = fcount_q;
`else
  assign FetchCount = 16'h0000;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch: table of per-cycle stimulus and expected outputs,
// plus a hand-written asynchronous reset sequence.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [10:0] StartAddr;
  logic        Stall;
  logic        BranchEn;
  logic        BranchRel;
  logic [10:0] Target;
  logic [8:0]  InstIn;
  logic [10:0] InstAddress;
  logic [8:0]  InstReg;
  logic [10:0] InstRegAddr;
  logic        InstValid;
  logic        Done;
  logic [15:0] FetchCount;

  logic [8:0] rom [0:2047];
  assign InstIn = rom[InstAddress];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .BranchEn(BranchEn), .BranchRel(BranchRel), .Target(Target),
    .InstIn(InstIn), .InstAddress(InstAddress), .InstReg(InstReg),
    .InstRegAddr(InstRegAddr), .InstValid(InstValid), .Done(Done),
    .FetchCount(FetchCount)
  );

  typedef struct {
    logic        st;
    logic [10:0] sa;
    logic        sl;
    logic        be;
    logic        br;
    logic [10:0] tg;
    logic [10:0] ia;
    logic [8:0]  ir;
    logic [10:0] ira;
    logic        v;
    logic        d;
    logic [15:0] fc;
  } vec_t;

  function automatic vec_t mk(logic st, logic [10:0] sa, logic sl, logic be, logic br,
                              logic [10:0] tg, logic [10:0] ia, logic [8:0] ir,
                              logic [10:0] ira, logic v, logic d, logic [15:0] fc);
    vec_t r;
    r.st = st; r.sa = sa; r.sl = sl; r.be = be; r.br = br; r.tg = tg;
    r.ia = ia; r.ir = ir; r.ira = ira; r.v = v; r.d = d; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_fc(input int idx, input logic [15:0] exp);
`ifdef FETCH_COUNT_EN
    chk("FetchCount", idx, 32'(FetchCount), 32'(exp));
`else
    chk("FetchCount", idx, 32'(FetchCount), 32'(16'h0000 & exp));
`endif
  endtask

  task automatic drive(input logic st, input logic [10:0] sa, input logic sl,
                       input logic be, input logic br, input logic [10:0] tg);
    Start = st; StartAddr = sa; Stall = sl; BranchEn = be; BranchRel = br; Target = tg;
  endtask

  vec_t vecs [0:26];

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = {1'b0, 8'(i)};
    rom[0] = 9'h001;
    rom[1] = 9'h049;
    rom[2] = 9'h1FF;

    //        st sa      sl be br tg       ia      ir      ira     v d fc
    vecs[0]  = mk(0, 11'h000, 1, 1, 0, 11'h010, 11'h000, 9'h000, 11'h000, 0, 0, 0); // IDLE ignores
    vecs[1]  = mk(1, 11'h000, 0, 0, 0, 11'h000, 11'h000, 9'h000, 11'h000, 0, 0, 0);
    vecs[2]  = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h001, 9'h001, 11'h000, 1, 0, 1);
    vecs[3]  = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h002, 9'h049, 11'h001, 1, 0, 2);
    vecs[4]  = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h002, 9'h1FF, 11'h002, 1, 1, 3);
    vecs[5]  = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h002, 9'h1FF, 11'h002, 0, 1, 3);
    vecs[6]  = mk(0, 11'h000, 1, 1, 0, 11'h010, 11'h002, 9'h1FF, 11'h002, 0, 1, 3); // HALT ignores
    vecs[7]  = mk(1, 11'h000, 0, 0, 0, 11'h000, 11'h000, 9'h1FF, 11'h002, 0, 0, 0);
    vecs[8]  = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h001, 9'h001, 11'h000, 1, 0, 1);
    vecs[9]  = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h002, 9'h049, 11'h001, 1, 0, 2);
    vecs[10] = mk(0, 11'h000, 1, 0, 0, 11'h000, 11'h002, 9'h049, 11'h001, 1, 0, 2); // stall x3
    vecs[11] = mk(0, 11'h000, 1, 0, 0, 11'h000, 11'h002, 9'h049, 11'h001, 1, 0, 2);
    vecs[12] = mk(0, 11'h000, 1, 0, 0, 11'h000, 11'h002, 9'h049, 11'h001, 1, 0, 2);
    vecs[13] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h002, 9'h1FF, 11'h002, 1, 1, 3);
    vecs[14] = mk(1, 11'h020, 0, 0, 0, 11'h000, 11'h020, 9'h1FF, 11'h002, 0, 0, 0);
    vecs[15] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h021, 9'h020, 11'h020, 1, 0, 1);
    vecs[16] = mk(0, 11'h000, 1, 1, 0, 11'h010, 11'h010, 9'h020, 11'h020, 0, 0, 1); // abs branch under stall
    vecs[17] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h011, 9'h010, 11'h010, 1, 0, 2);
    vecs[18] = mk(1, 11'h004, 0, 0, 0, 11'h000, 11'h004, 9'h010, 11'h010, 0, 0, 0);
    vecs[19] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h005, 9'h004, 11'h004, 1, 0, 1);
    vecs[20] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h006, 9'h005, 11'h005, 1, 0, 2);
    vecs[21] = mk(0, 11'h000, 0, 1, 1, 11'h7FF, 11'h004, 9'h005, 11'h005, 0, 0, 2); // 5 + (-1)
    vecs[22] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h005, 9'h004, 11'h004, 1, 0, 3);
    vecs[23] = mk(1, 11'h7FE, 0, 0, 0, 11'h000, 11'h7FE, 9'h004, 11'h004, 0, 0, 0);
    vecs[24] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h7FF, 9'h0FE, 11'h7FE, 1, 0, 1);
    vecs[25] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h000, 9'h0FF, 11'h7FF, 1, 0, 2); // PC wrap
    vecs[26] = mk(0, 11'h000, 0, 0, 0, 11'h000, 11'h001, 9'h001, 11'h000, 1, 0, 3);

    Reset = 1'b0;
    drive(0, 11'h0, 0, 0, 0, 11'h0);
    #2;
    chk("rst_InstAddress", -1, 32'(InstAddress), 32'h0);
    chk("rst_InstValid",   -1, 32'(InstValid),   32'h0);
    chk("rst_Done",        -1, 32'(Done),        32'h0);
    chk_fc(-1, 16'h0);
    #1 Reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].st, vecs[i].sa, vecs[i].sl, vecs[i].be, vecs[i].br, vecs[i].tg);
      @(posedge Clk);
      #1;
      chk("InstAddress", i, 32'(InstAddress), 32'(vecs[i].ia));
      chk("InstReg",     i, 32'(InstReg),     32'(vecs[i].ir));
      chk("InstRegAddr", i, 32'(InstRegAddr), 32'(vecs[i].ira));
      chk("InstValid",   i, 32'(InstValid),   32'(vecs[i].v));
      chk("Done",        i, 32'(Done),        32'(vecs[i].d));
      chk_fc(i, vecs[i].fc);
      $display("step %0d: IA=%h IR=%h IRA=%h V=%0d D=%0d FC=%0d", i, InstAddress, InstReg,
               InstRegAddr, InstValid, Done, FetchCount);
    end

    // Asynchronous reset while running at PC=7.
    drive(1, 11'h005, 0, 0, 0, 11'h0);
    @(posedge Clk); #1;
    drive(0, 11'h0, 0, 0, 0, 11'h0);
    repeat (2) @(posedge Clk);
    #1;
    chk("pre_reset_pc", 100, 32'(InstAddress), 32'h7);
    chk_fc(100, 16'h2);
    #3 Reset = 1'b0;
    #1;
    chk("async_InstAddress", 101, 32'(InstAddress), 32'h0);
    chk("async_InstReg",     101, 32'(InstReg),     32'h0);
    chk("async_InstRegAddr", 101, 32'(InstRegAddr), 32'h0);
    chk("async_InstValid",   101, 32'(InstValid),   32'h0);
    chk("async_Done",        101, 32'(Done),        32'h0);
    chk_fc(101, 16'h0);
    $display("async reset: IA=%h IR=%h IRA=%h V=%0d", InstAddress, InstReg, InstRegAddr, InstValid);
    #2 Reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("idle_InstAddress", 102 + i, 32'(InstAddress), 32'h0);
      chk("idle_InstValid",   102 + i, 32'(InstValid),   32'h0);
      chk("idle_InstReg",     102 + i, 32'(InstReg),     32'h0);
      $display("idle cycle %0d: IA=%h V=%0d", i, InstAddress, InstValid);
    end

    drive(1, 11'h003, 0, 0, 0, 11'h0);
    @(posedge Clk); #1;
    drive(0, 11'h0, 0, 0, 0, 11'h0);
    @(posedge Clk); #1;
    chk("restart_InstRegAddr", 110, 32'(InstRegAddr), 32'h3);
    chk("restart_InstReg",     110, 32'(InstReg),     32'h003);
    chk("restart_InstValid",   110, 32'(InstValid),   32'h1);
    chk("restart_InstAddress", 110, 32'(InstAddress), 32'h4);
    $display("restart: IA=%h IR=%h IRA=%h V=%0d", InstAddress, InstReg, InstRegAddr, InstValid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter A_WIDTH, default 11, instruction address width (ROM depth 2**A_WIDTH).
REQ-002 SHALL have parameter I_WIDTH, default 9, instruction word width.
REQ-003 SHALL have parameter HALT_WORD, default all ones, the halt encoding.
REQ-004 SHALL have port Clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port Start, input, 1, one-cycle pulse that begins execution at StartAddr.
REQ-007 SHALL have port StartAddr, input, A_WIDTH, entry address.
REQ-008 SHALL have port Stall, input, 1, downstream hold request.
REQ-009 SHALL have port BranchEn, input, 1, redirect request from execute.
REQ-010 SHALL have port BranchRel, input, 1, 1 = PC-relative target, 0 = absolute target.
REQ-011 SHALL have port Target, input, A_WIDTH, absolute address or two's-complement offset.
REQ-012 SHALL have port InstIn, input, I_WIDTH, combinational ROM read data for InstAddress.
REQ-013 SHALL have port InstAddress, output, A_WIDTH, current PC driven to the ROM.
REQ-014 SHALL have port InstReg, output, I_WIDTH, registered instruction for decode.
REQ-015 SHALL have port InstRegAddr, output, A_WIDTH, address InstReg was fetched from.
REQ-016 SHALL have port InstValid, output, 1, InstReg holds a live instruction.
REQ-017 SHALL have port Done, output, 1, high while in HALT.
REQ-018 SHALL have port FetchCount, output, 16, fetched-instruction count (see Configuration).

Function
REQ-019 SHALL implement states IDLE, RUN and HALT.
REQ-020 SHALL drive InstAddress combinationally from the PC register, giving one-cycle fetch latency from PC to InstReg.
REQ-021 SHALL, on Start in any state, go to RUN with PC<=StartAddr, InstValid<=0; Start SHALL override all other inputs.
REQ-022 SHALL, in RUN with no Start, no BranchEn and no Stall, load InstReg<=InstIn, InstRegAddr<=PC, InstValid<=1 and PC<=PC+1.
REQ-023 SHALL wrap PC from 2**A_WIDTH-1 to 0.
REQ-024 SHALL, in RUN with Stall and no BranchEn, hold PC, InstReg, InstRegAddr and InstValid.
REQ-025 SHALL, in RUN with BranchEn, set PC<=Target when BranchRel=0, PC<=InstRegAddr+sign-extended Target (modulo 2**A_WIDTH) when BranchRel=1, and InstValid<=0, regardless of Stall.
REQ-026 SHALL, when a REQ-022 load captures InstIn==HALT_WORD, enter HALT with InstValid=1 for that one cycle and PC unchanged.
REQ-027 SHALL, in HALT, hold PC, drive InstValid=0 after the first cycle, Done=1, and ignore Stall and BranchEn.
REQ-028 SHALL, in IDLE, hold PC and keep InstValid=0 and Done=0, ignoring Stall and BranchEn.

Reset
REQ-029 SHALL, on Reset low, immediately force state IDLE, PC=0, InstReg=0, InstRegAddr=0, InstValid=0, Done=0 and FetchCount=0, including mid-RUN.
REQ-030 SHALL leave IDLE only on Start after Reset deasserts.

Configuration
REQ-031 SHALL use macro FETCH_COUNT_EN to include a 16-bit saturating counter of REQ-022 loads, cleared by Reset and by Start and held at 16'hFFFF.
REQ-032 SHALL, without FETCH_COUNT_EN, tie FetchCount to 0 and contain no counter logic.

Verification
REQ-033 SHALL cover: Reset low, Start with StartAddr=0, ROM {0:0x001, 1:0x049, 2:0x1FF} -> InstValid on 3 consecutive cycles with InstRegAddr 0,1,2, then Done=1 and InstAddress held at 2.
REQ-034 SHALL cover: Stall held 3 cycles while InstRegAddr=1 -> InstReg, InstRegAddr and InstAddress unchanged for 3 cycles, then the sequence resumes at address 2.
REQ-035 SHALL cover: BranchEn with BranchRel=0, Target=0x10 while Stall=1 -> next cycle InstValid=0, InstAddress=0x10; InstRegAddr=0x10 one cycle later.
REQ-036 SHALL cover: InstRegAddr=5, BranchRel=1, Target=all ones (-1) -> PC=4; also PC=2047 with no branch -> PC=0.
REQ-037 SHALL cover: Reset low mid-RUN at PC=7 -> all outputs zero asynchronously, IDLE held until Start; with FETCH_COUNT_EN set, FetchCount counts 3 for REQ-033 and 0 after Reset.
